lcd_reader: RTL and testbench

Read-side controller for the Spartan-3E character LCD (HD44780-compatible, 4-bit bus). It runs one complete read transaction: RW high, high nibble then low nibble, each strobed by its own E pulse. The two nibbles are assembled into a byte. In busy-poll mode it repeats the busy-flag/address read until BF clears or a poll limit is reached. It sits beside the LCD writer on the same LCD_E/RS/RW/SF_D[11:8] pins. An upper-level arbiter owns the pins and uses `oBus_Release` to tri-state SF_D while this block reads.

---
 rtl/lcd_reader_pkg.sv | 31 +++
 rtl/lcd_reader_if.sv | 28 ++
 rtl/lcd_cycle_timer.sv | 28 ++
 rtl/lcd_reader.sv | 161 ++++++++++++++++
 tb/tb_lcd_reader.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_reader_pkg.sv
// Shared types and timing defaults for the character-LCD read/write controllers.
package lcd_reader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StEHiNib,
    StGap,
    StELoNib,
    StHold,
    StDone
  } state_e;

  // Default timing in 50 MHz clock cycles.
  localparam int unsigned DefSetupCycles      = 2;
  localparam int unsigned DefEnableHighCycles = 12;
  localparam int unsigned DefGapCycles        = 50;
  localparam int unsigned DefMaxPolls         = 255;

  // Wide enough for any phase up to 256 cycles.
  localparam int unsigned TimerWidth = 8;

  // RS codes, shared with the writer.
  localparam logic RsInstr = 1'b0;
  localparam logic RsData  = 1'b1;

  function automatic logic [TimerWidth-1:0] load_count(input int unsigned cycles);
    return TimerWidth'(cycles - 1);
  endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// Request/status and LCD pin bundle between the pin arbiter (master) and the reader (slave).
interface lcd_reader_if;
  logic       read_start;
  logic       register_select;
  logic       poll_busy;
  logic [3:0] data_nibble;
  logic       lcd_enable;
  logic       lcd_register_select;
  logic       lcd_read_write;
  logic       bus_release;
  logic [7:0] data_byte;
  logic       busy_flag;
  logic       read_done;
  logic       timeout;
  logic       busy;

  modport master (
    output read_start, register_select, poll_busy, data_nibble,
    input  lcd_enable, lcd_register_select, lcd_read_write, bus_release,
    input  data_byte, busy_flag, read_done, timeout, busy
  );

  modport slave (
    input  read_start, register_select, poll_busy, data_nibble,
    output lcd_enable, lcd_register_select, lcd_read_write, bus_release,
    output data_byte, busy_flag, read_done, timeout, busy
  );
endinterface

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter with zero flag; times every phase of the LCD read and write sequencers.
module lcd_cycle_timer
  import lcd_reader_pkg::*;
#(
  parameter int unsigned Width = TimerWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 4-bit read sequencer: two E-strobed nibbles per read, optional busy-flag polling.
module lcd_reader
  import lcd_reader_pkg::*;
#(
  parameter int unsigned SetupCycles      = DefSetupCycles,
  parameter int unsigned EnableHighCycles = DefEnableHighCycles,
  parameter int unsigned GapCycles        = DefGapCycles,
  parameter int unsigned MaxPolls         = DefMaxPolls
) (
  input logic         clk,
  input logic         rst,
  lcd_reader_if.slave bus
);

  localparam int unsigned PollWidth = (MaxPolls > 1) ? $clog2(MaxPolls) : 1;

  state_e                 state_q;
  logic                   poll_q;
  logic                   gap_poll_q;  // current GAP is the inter-poll wait, not the nibble gap
  logic [7:0]             byte_q;
  logic [PollWidth-1:0]   polls_q;
  logic                   timer_load;
  logic [TimerWidth-1:0]  timer_value;
  logic                   timer_zero;
  logic                   repoll;

  assign repoll = poll_q && byte_q[7] && (32'(polls_q) < MaxPolls - 1);

  lcd_cycle_timer #(
    .Width(TimerWidth)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .load_value(timer_value),
    .zero      (timer_zero)
  );

  // Reload the timer with the duration of whichever state is entered next.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    unique case (state_q)
      StIdle: begin
        timer_load  = bus.read_start;
        timer_value = load_count(SetupCycles);
      end
      StSetup: begin
        timer_load  = timer_zero;
        timer_value = load_count(EnableHighCycles);
      end
      StEHiNib: begin
        timer_load  = timer_zero;
        timer_value = load_count(GapCycles);
      end
      StGap: begin
        timer_load  = timer_zero;
        timer_value = gap_poll_q ? load_count(SetupCycles) : load_count(EnableHighCycles);
      end
      StELoNib: begin
        timer_load  = timer_zero;
        timer_value = load_count(SetupCycles);
      end
      StHold: begin
        timer_load  = timer_zero;
        timer_value = load_count(GapCycles);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                 <= StIdle;
      poll_q                  <= 1'b0;
      gap_poll_q              <= 1'b0;
      byte_q                  <= '0;
      polls_q                 <= '0;
      bus.lcd_enable          <= 1'b0;
      bus.lcd_register_select <= 1'b0;
      bus.lcd_read_write      <= 1'b0;
      bus.bus_release         <= 1'b0;
      bus.data_byte           <= '0;
      bus.busy_flag           <= 1'b0;
      bus.read_done           <= 1'b0;
      bus.timeout             <= 1'b0;
      bus.busy                <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.read_start) begin
            bus.lcd_register_select <= bus.register_select;
            poll_q                  <= bus.poll_busy && (bus.register_select == RsInstr);
            polls_q                 <= '0;
            gap_poll_q              <= 1'b0;
            bus.lcd_read_write      <= 1'b1;
            bus.bus_release         <= 1'b1;
            bus.busy                <= 1'b1;
            state_q                 <= StSetup;
          end
        end
        StSetup: begin
          if (timer_zero) begin
            bus.lcd_enable <= 1'b1;
            state_q        <= StEHiNib;
          end
        end
        StEHiNib: begin
          if (timer_zero) begin
            byte_q[7:4]    <= bus.data_nibble;
            bus.lcd_enable <= 1'b0;
            gap_poll_q     <= 1'b0;
            state_q        <= StGap;
          end
        end
        StGap: begin
          if (timer_zero) begin
            if (gap_poll_q) begin
              state_q <= StSetup;
            end else begin
              bus.lcd_enable <= 1'b1;
              state_q        <= StELoNib;
            end
          end
        end
        StELoNib: begin
          if (timer_zero) begin
            byte_q[3:0]    <= bus.data_nibble;
            bus.lcd_enable <= 1'b0;
            state_q        <= StHold;
          end
        end
        StHold: begin
          if (timer_zero) begin
            if (repoll) begin
              polls_q    <= polls_q + PollWidth'(1);
              gap_poll_q <= 1'b1;
              state_q    <= StGap;
            end else begin
              bus.data_byte           <= byte_q;
              bus.busy_flag           <= (bus.lcd_register_select == RsInstr) && byte_q[7];
              bus.timeout             <= poll_q && byte_q[7];
              bus.read_done           <= 1'b1;
              bus.lcd_read_write      <= 1'b0;
              bus.bus_release         <= 1'b0;
              bus.lcd_register_select <= 1'b0;
              state_q                 <= StDone;
            end
          end
        end
        StDone: begin
          bus.read_done <= 1'b0;
          bus.busy      <= 1'b0;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: single reads, busy polling, poll timeout, reset abort, ignored start.
module tb_lcd_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  lcd_reader_if if1 ();
  lcd_reader_if if2 ();

  lcd_reader u1 (
    .clk(clk),
    .rst(rst),
    .bus(if1)
  );

  lcd_reader #(
    .MaxPolls(4)
  ) u2 (
    .clk(clk),
    .rst(rst),
    .bus(if2)
  );

  int tests    = 0;
  int fails    = 0;
  int prot_err = 0;

  // LCD model for u1: each read returns the next resp[] byte, high nibble on the first E.
  logic [7:0] resp [4];
  logic [7:0] cur;
  int         e_falls  = 0;
  int         base     = 0;
  int         e2_rises = 0;
  int         rd_idx;

  always @(negedge if1.lcd_enable) e_falls++;
  always @(posedge if2.lcd_enable) e2_rises++;

  always_comb begin
    rd_idx = (e_falls - base) / 2;
    if (rd_idx > 3) rd_idx = 3;
    if (rd_idx < 0) rd_idx = 0;
    cur = resp[rd_idx];
    if1.data_nibble = (((e_falls - base) % 2) == 1) ? cur[3:0] : cur[7:4];
  end

  assign if2.data_nibble = 4'hF;

  always @(negedge clk) begin
    if (if1.lcd_enable && !if1.lcd_read_write) begin
      prot_err++;
      $display("FAIL protocol_rw_low_with_e: observed rw=0 expected rw=1");
    end
    if (if1.lcd_read_write && !if1.bus_release) begin
      prot_err++;
      $display("FAIL protocol_release: observed release=0 expected release=1");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start a read on u1 and watch it; call and return #1 after a rising edge.
  task automatic run1(input logic rs, input logic poll, input int limit, input int pulse_at,
                      input int extra, output int done_cyc, output int done_cnt,
                      output int rises, output int hi_cycles, output int rise1,
                      output int rise2, output logic rs_c1);
    int   c;
    logic prev_e;
    base                = e_falls;
    if1.register_select = rs;
    if1.poll_busy       = poll;
    if1.read_start      = 1'b1;
    @(posedge clk);
    #1;
    if1.read_start = 1'b0;
    c = 1; prev_e = 1'b0; done_cyc = 0; done_cnt = 0;
    rises = 0; hi_cycles = 0; rise1 = 0; rise2 = 0;
    rs_c1 = if1.lcd_register_select;
    while (c <= limit) begin
      if1.read_start = (c == pulse_at);
      if (if1.lcd_enable) hi_cycles++;
      if (if1.lcd_enable && !prev_e) begin
        rises++;
        if (rises == 1) rise1 = c;
        else if (rises == 2) rise2 = c;
      end
      prev_e = if1.lcd_enable;
      if (if1.read_done) begin
        done_cnt++;
        done_cyc = c;
        break;
      end
      @(posedge clk);
      #1;
      c++;
    end
    if1.read_start = 1'b0;
    for (int i = 0; i < extra; i++) begin
      @(posedge clk);
      #1;
      if (if1.read_done) done_cnt++;
    end
  endtask

  int   dc, dn, rs_n, hi, r1, r2, c2, base2;
  logic rsc;

  initial begin
    if1.read_start = 1'b0; if1.register_select = 1'b0; if1.poll_busy = 1'b0;
    if2.read_start = 1'b0; if2.register_select = 1'b0; if2.poll_busy = 1'b0;
    for (int i = 0; i < 4; i++) resp[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_enable", 32'(if1.lcd_enable), 0);
    chk("reset_rs", 32'(if1.lcd_register_select), 0);
    chk("reset_rw", 32'(if1.lcd_read_write), 0);
    chk("reset_release", 32'(if1.bus_release), 0);
    chk("reset_byte", 32'(if1.data_byte), 0);
    chk("reset_status", 32'({if1.busy_flag, if1.read_done, if1.timeout, if1.busy}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Data RAM read returning 8'hA5.
    resp[0] = 8'hA5;
    run1(1'b1, 1'b0, 200, 0, 0, dc, dn, rs_n, hi, r1, r2, rsc);
    chk("rs1_done_cycle", 32'(dc), 79);
    chk("rs1_byte", 32'(if1.data_byte), 32'h A5);
    chk("rs1_timeout", 32'(if1.timeout), 0);
    chk("rs1_rs_driven", 32'(rsc), 1);
    chk("rs1_e_rises", 32'(rs_n), 2);
    chk("rs1_e_high_cycles", 32'(hi), 24);
    chk("rs1_first_rise", 32'(r1), 3);
    chk("rs1_second_rise", 32'(r2), 65);
    @(posedge clk);
    #1;
    chk("rs1_done_one_cycle", 32'(if1.read_done), 0);
    chk("rs1_byte_holds", 32'(if1.data_byte), 32'h A5);
    chk("rs1_idle_outputs", 32'({if1.busy, if1.lcd_read_write, if1.bus_release}), 0);

    // Busy-flag read, no polling.
    resp[0] = 8'h8C;
    run1(1'b0, 1'b0, 200, 0, 0, dc, dn, rs_n, hi, r1, r2, rsc);
    chk("bf_done_cycle", 32'(dc), 79);
    chk("bf_byte", 32'(if1.data_byte), 32'h8C);
    chk("bf_busy_flag", 32'(if1.busy_flag), 1);
    chk("bf_timeout", 32'(if1.timeout), 0);
    chk("bf_single_iteration", 32'(rs_n), 2);
    @(posedge clk);
    #1;

    // Poll: BF=1 three times, then 8'h0C.
    resp[0] = 8'h81; resp[1] = 8'h82; resp[2] = 8'h83; resp[3] = 8'h0C;
    run1(1'b0, 1'b1, 700, 0, 0, dc, dn, rs_n, hi, r1, r2, rsc);
    chk("poll_done_cycle", 32'(dc), 463);
    chk("poll_byte", 32'(if1.data_byte), 32'h0C);
    chk("poll_timeout", 32'(if1.timeout), 0);
    chk("poll_busy_flag", 32'(if1.busy_flag), 0);
    chk("poll_e_rises", 32'(rs_n), 8);
    @(posedge clk);
    #1;

    // Poll timeout on u2 (MaxPolls=4, BF stuck).
    base2 = e2_rises;
    if2.register_select = 1'b0;
    if2.poll_busy       = 1'b1;
    if2.read_start      = 1'b1;
    @(posedge clk);
    #1;
    if2.read_start = 1'b0;
    c2 = 1;
    while (!if2.read_done && c2 < 700) begin
      @(posedge clk);
      #1;
      c2++;
    end
    chk("to_done_cycle", 32'(c2), 463);
    chk("to_iterations", 32'((e2_rises - base2) / 2), 4);
    chk("to_timeout", 32'(if2.timeout), 1);
    chk("to_busy_flag", 32'(if2.busy_flag), 1);
    chk("to_byte", 32'(if2.data_byte), 32'hFF);
    @(posedge clk);
    #1;

    // Reset during the second-nibble E pulse.
    resp[0] = 8'h3C;
    run1(1'b1, 1'b0, 65, 0, 0, dc, dn, rs_n, hi, r1, r2, rsc);
    chk("rst_e_high_before", 32'(if1.lcd_enable), 1);
    rst = 1'b1;
    #1;
    chk("rst_async_drop", 32'({if1.lcd_enable, if1.lcd_read_write, if1.bus_release}), 0);
    chk("rst_idle", 32'(if1.busy), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (if1.read_done) dn++;
    end
    chk("rst_no_done", 32'(dn), 0);

    // Start pulsed during GAP is ignored.
    resp[0] = 8'h5A;
    run1(1'b1, 1'b0, 200, 30, 150, dc, dn, rs_n, hi, r1, r2, rsc);
    chk("gap_start_done_cycle", 32'(dc), 79);
    chk("gap_start_one_done", 32'(dn), 1);
    chk("gap_start_byte", 32'(if1.data_byte), 32'h5A);

    chk("protocol_errors", 32'(prot_err), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
